stream_serializer: RTL and testbench

- Width-down transmitter for the valid/ack stream protocol used by the FIFOs.
- Accepts one wide word per handshake and emits it as RATIO narrow beats on a valid/ack output, flagging the final beat with out_last.
- Sits downstream of a wide FIFO, typically feeding a narrow bus or link.
- Registered output; full throughput of one beat per cycle with no bubble between words.

---
 rtl/stream_pkg.sv | 20 ++
 rtl/stream_serializer.sv | 121 ++++++++++++
 tb/tb_stream_serializer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pkg
//  Description : Shared helpers for the valid/ack width converters
//                (serializer and matching deserializer).
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

  // Bits needed to count 0..n-1, never less than one so that a counter
  // for a single-beat converter still has a legal declaration.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_serializer
//  Description : Width-down valid/ack converter. Takes one IN_WIDTH word per
//                handshake and emits RATIO beats of IN_WIDTH/RATIO bits,
//                marking the final beat with out_last. The next word is
//                accepted on the last beat, so words stream without bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_serializer
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [IN_WIDTH-1:0]       in,
  input  logic                      in_valid,
  output logic                      in_ack,
  output logic [IN_WIDTH/RATIO-1:0] out,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ack,
  output logic                      busy
);

  localparam int              OUT_W     = IN_WIDTH / RATIO;
  localparam int              CNT_W     = clog2_min1(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // A word must split into whole beats; anything else is a wiring mistake.
  generate
    if (RATIO < 1 || (IN_WIDTH % RATIO) != 0) begin : g_bad_params
      $error("stream_serializer: IN_WIDTH must be a positive multiple of RATIO");
    end
  endgenerate

  logic [0:0]          r_state;
  logic [0:0]          w_state_next;
  logic [IN_WIDTH-1:0] r_word;
  logic [CNT_W-1:0]    r_beat;
  logic [CNT_W-1:0]    w_sel;
  logic [OUT_W-1:0]    w_slice;
  logic                w_loaded;
  logic                w_at_last;
  logic                w_in_xfer;
  logic                w_out_xfer;

  assign w_at_last  = (r_beat == LAST_BEAT);
  assign w_in_xfer  = in_valid && in_ack;
  assign w_out_xfer = out_valid && out_ack;

  // State register: IDLE means nothing held, SEND means a word is being emitted.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: leave SEND only when the last beat goes out with no refill.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_in_xfer) w_state_next = S_SEND;
      S_SEND:  if (w_out_xfer && w_at_last && !w_in_xfer) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: handshake flags; in_ack is held low while reset is asserted.
  always_comb begin
    w_loaded  = (r_state == S_SEND);
    in_ack    = !reset && (!w_loaded || (w_at_last && out_ack));
    out_valid = w_loaded;
    out_last  = w_loaded && w_at_last;
    busy      = w_loaded;
  end

  // Hold register and beat counter; a refill on the last beat restarts at beat 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word <= '0;
      r_beat <= '0;
    end else if (w_in_xfer) begin
      r_word <= in;
      r_beat <= '0;
    end else if (w_out_xfer) begin
      r_beat <= w_at_last ? '0 : r_beat + 1'b1;
    end
  end

  // Slice select: beat index maps directly or mirrored depending on beat order.
  always_comb begin
    w_sel   = LSB_FIRST ? r_beat : (LAST_BEAT - r_beat);
    w_slice = r_word[OUT_W-1:0];
    for (int k = 0; k < RATIO; k++) begin
      if (w_sel == CNT_W'(k)) w_slice = r_word[k*OUT_W +: OUT_W];
    end
  end

  assign out = w_slice;

`ifdef FORMAL
  a_beat_range: assert property (@(posedge clock) disable iff (reset)
    r_beat <= LAST_BEAT);
  a_valid_loaded: assert property (@(posedge clock)
    out_valid == (r_state == S_SEND));
  a_stable: assert property (@(posedge clock) disable iff (reset)
    (out_valid && !out_ack) |=> (out_valid && $stable(out) && $stable(out_last)));
  c_back_to_back: cover property (@(posedge clock) disable iff (reset)
    (out_valid && out_last && out_ack && in_valid) ##1 out_valid);
  c_reset_in_send: cover property (@(posedge clock)
    out_valid && reset);
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_serializer
//  Description : Scoreboard bench for stream_serializer. Three instances:
//                default (LSB first, 32->8), MSB first, and 24->8 (RATIO=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_serializer;

  logic clk;
  logic rst;

  // Instance A: defaults
  logic [31:0] a_in;
  logic        a_in_valid, a_in_ack, a_out_valid, a_out_last, a_out_ack, a_busy;
  logic [7:0]  a_out;
  // Instance B: MSB slice first
  logic [31:0] b_in;
  logic        b_in_valid, b_in_ack, b_out_valid, b_out_last, b_out_ack, b_busy;
  logic [7:0]  b_out;
  // Instance C: RATIO=3, 24-bit words
  logic [23:0] c_in;
  logic        c_in_valid, c_in_ack, c_out_valid, c_out_last, c_out_ack, c_busy;
  logic [7:0]  c_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected beats, {last, data}
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] q_c[$];

  stream_serializer #(.IN_WIDTH(32), .RATIO(4), .LSB_FIRST(1'b1)) dut_a (
    .clock(clk), .reset(rst), .in(a_in), .in_valid(a_in_valid), .in_ack(a_in_ack),
    .out(a_out), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_ack(a_out_ack), .busy(a_busy));

  stream_serializer #(.IN_WIDTH(32), .RATIO(4), .LSB_FIRST(1'b0)) dut_b (
    .clock(clk), .reset(rst), .in(b_in), .in_valid(b_in_valid), .in_ack(b_in_ack),
    .out(b_out), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_ack(b_out_ack), .busy(b_busy));

  stream_serializer #(.IN_WIDTH(24), .RATIO(3), .LSB_FIRST(1'b1)) dut_c (
    .clock(clk), .reset(rst), .in(c_in), .in_valid(c_in_valid), .in_ack(c_in_ack),
    .out(c_out), .out_valid(c_out_valid), .out_last(c_out_last),
    .out_ack(c_out_ack), .busy(c_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected beat per output transfer
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ack) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_beat: got 0x%0h, required none", a_out);
      end else chk("a_beat", {23'd0, a_out_last, a_out}, {23'd0, q_a.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ack) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_beat: got 0x%0h, required none", b_out);
      end else chk("b_beat", {23'd0, b_out_last, b_out}, {23'd0, q_b.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && c_out_valid && c_out_ack) begin
      if (q_c.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL c_unexpected_beat: got 0x%0h, required none", c_out);
      end else chk("c_beat", {23'd0, c_out_last, c_out}, {23'd0, q_c.pop_front()});
    end
  end

  // Bounded wait until the selected instance has gone idle
  task automatic wait_idle(input int which);
    logic v;
    int   cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      case (which)
        0:       v = a_out_valid;
        1:       v = b_out_valid;
        default: v = c_out_valid;
      endcase
      cyc++;
    end while (v && cyc < 20);
    chk("idle_reached", {31'd0, v}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_in = '0; a_in_valid = 1'b0; a_out_ack = 1'b0;
    b_in = '0; b_in_valid = 1'b0; b_out_ack = 1'b0;
    c_in = '0; c_in_valid = 1'b0; c_out_ack = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ack",    {31'd0, a_in_ack},    32'd0);
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_out_last",  {31'd0, a_out_last},  32'd0);
    chk("rst_busy",      {31'd0, a_busy},      32'd0);
    chk("rst_out",       {24'd0, a_out},       32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ack_a", {31'd0, a_in_ack}, 32'd1);
    chk("post_rst_in_ack_b", {31'd0, b_in_ack}, 32'd1);
    chk("post_rst_in_ack_c", {31'd0, c_in_ack}, 32'd1);

    // Single word, LSB first, one-cycle latency
    a_in = 32'hDDCCBBAA; a_in_valid = 1'b1; a_out_ack = 1'b1;
    q_a.push_back({1'b0, 8'hAA}); q_a.push_back({1'b0, 8'hBB});
    q_a.push_back({1'b0, 8'hCC}); q_a.push_back({1'b1, 8'hDD});
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    chk("t1_first_valid", {31'd0, a_out_valid}, 32'd1);
    chk("t1_first_data",  {24'd0, a_out},       32'hAA);
    wait_idle(0);

    // Two words back-to-back, no bubble
    a_in = 32'h44332211; a_in_valid = 1'b1;
    q_a.push_back({1'b0, 8'h11}); q_a.push_back({1'b0, 8'h22});
    q_a.push_back({1'b0, 8'h33}); q_a.push_back({1'b1, 8'h44});
    @(posedge clk); #1 a_in = 32'h88776655;
    q_a.push_back({1'b0, 8'h55}); q_a.push_back({1'b0, 8'h66});
    q_a.push_back({1'b0, 8'h77}); q_a.push_back({1'b1, 8'h88});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_in_ack", {31'd0, a_in_ack}, (k == 3) ? 32'd1 : 32'd0);
      chk("t2_valid_w0", {31'd0, a_out_valid}, 32'd1);
    end
    @(posedge clk); #1 a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_valid_w1", {31'd0, a_out_valid}, 32'd1);
    end
    wait_idle(0);

    // Backpressure while 0xBB is presented
    a_in = 32'hDDCCBBAA; a_in_valid = 1'b1;
    q_a.push_back({1'b0, 8'hAA}); q_a.push_back({1'b0, 8'hBB});
    q_a.push_back({1'b0, 8'hCC}); q_a.push_back({1'b1, 8'hDD});
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(posedge clk); #1 a_out_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_hold_out",   {24'd0, a_out},       32'hBB);
      chk("t3_hold_valid", {31'd0, a_out_valid}, 32'd1);
      chk("t3_hold_last",  {31'd0, a_out_last},  32'd0);
      chk("t3_hold_in_ack",{31'd0, a_in_ack},    32'd0);
      @(posedge clk);
    end
    #1 a_out_ack = 1'b1;
    wait_idle(0);

    // Reset after 0xBB is transferred; the rest of the word is discarded
    a_in = 32'hDDCCBBAA; a_in_valid = 1'b1;
    q_a.push_back({1'b0, 8'hAA}); q_a.push_back({1'b0, 8'hBB});
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 begin rst = 1'b1; a_out_ack = 1'b0; end
    @(negedge clk);
    chk("t5_in_ack_in_rst", {31'd0, a_in_ack}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_valid_after_rst",  {31'd0, a_out_valid}, 32'd0);
    chk("t5_in_ack_after_rst", {31'd0, a_in_ack},    32'd0);
    chk("t5_busy_after_rst",   {31'd0, a_busy},      32'd0);
    @(posedge clk); #1 begin rst = 1'b0; a_out_ack = 1'b1; end
    @(negedge clk);
    chk("t5_in_ack_release", {31'd0, a_in_ack}, 32'd1);
    a_in = 32'h0F0E0D0C; a_in_valid = 1'b1;
    q_a.push_back({1'b0, 8'h0C}); q_a.push_back({1'b0, 8'h0D});
    q_a.push_back({1'b0, 8'h0E}); q_a.push_back({1'b1, 8'h0F});
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    chk("t5_first_beat", {24'd0, a_out}, 32'h0C);
    wait_idle(0);

    // MSB-first ordering
    b_in = 32'h12345678; b_in_valid = 1'b1; b_out_ack = 1'b1;
    q_b.push_back({1'b0, 8'h12}); q_b.push_back({1'b0, 8'h34});
    q_b.push_back({1'b0, 8'h56}); q_b.push_back({1'b1, 8'h78});
    @(posedge clk); #1 b_in_valid = 1'b0;
    wait_idle(1);

    // RATIO=3: two words back-to-back across the non-power-of-two wrap
    c_in = 24'hC0B0A0; c_in_valid = 1'b1; c_out_ack = 1'b1;
    q_c.push_back({1'b0, 8'hA0}); q_c.push_back({1'b0, 8'hB0}); q_c.push_back({1'b1, 8'hC0});
    @(posedge clk); #1 c_in = 24'h030201;
    q_c.push_back({1'b0, 8'h01}); q_c.push_back({1'b0, 8'h02}); q_c.push_back({1'b1, 8'h03});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_in_ack", {31'd0, c_in_ack}, (k == 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1 c_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_valid_w1", {31'd0, c_out_valid}, 32'd1);
    end
    @(negedge clk);
    chk("t6_idle_after_3", {31'd0, c_out_valid}, 32'd0);

    // Every expected beat must have been seen
    chk("q_a_drained", q_a.size(), 32'd0);
    chk("q_b_drained", q_b.size(), 32'd0);
    chk("q_c_drained", q_c.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "simulation timed out");
  end

endmodule
`default_nettype wire
